// File: rtl/mms_stream_ctrl.sv
// Frame max/min reducer: streams LEN unsigned operands through one shared compare/select stage.
// Optional out_idx position tracking is enabled by defining MMS_STREAM_IDX_EN.
`timescale 1ns/1ps
module mms_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              select,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    output logic              len_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef MMS_STREAM_IDX_EN
    ,
    output logic [CNT_W-1:0]  out_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  len_q_next;
    logic              sel_q;
    logic              sel_q_next;
    logic              len_err_next;
    logic              better;
`ifdef MMS_STREAM_IDX_EN
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  idx_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            len_q   <= '0;
            sel_q   <= 1'b0;
            len_err <= 1'b0;
`ifdef MMS_STREAM_IDX_EN
            idx     <= '0;
`endif
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            count   <= count_next;
            len_q   <= len_q_next;
            sel_q   <= sel_q_next;
            len_err <= len_err_next;
`ifdef MMS_STREAM_IDX_EN
            idx     <= idx_next;
`endif
        end
    end

    // Strict compare only, so ties leave the earlier operand in the accumulator.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        count_next   = count;
        len_q_next   = len_q;
        sel_q_next   = sel_q;
        len_err_next = 1'b0;
        better       = sel_q ? (in_data < acc) : (in_data > acc);
`ifdef MMS_STREAM_IDX_EN
        idx_next     = idx;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        sel_q_next = select;
                        len_q_next = len;
                        count_next = '0;
                        state_next = ACCUM;
                    end else begin
                        len_err_next = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if ((count == '0) || better) begin
                        acc_next = in_data;
`ifdef MMS_STREAM_IDX_EN
                        idx_next = count;
`endif
                    end
                    // count < len_q <= 2^CNT_W-1 here, so the increment cannot wrap.
                    count_next = count + CNT_W'(1);
                    if (count_next == len_q) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
`ifdef MMS_STREAM_IDX_EN
    assign out_idx   = idx;
`endif

endmodule

// File: tb/tb_mms_stream_ctrl.sv
// Directed testbench for mms_stream_ctrl; expected values are hand-computed from the frame data.
`timescale 1ns/1ps
module tb_mms_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       select = 1'b0;
    logic [3:0] len = 4'd0;
    logic       busy;
    logic       len_err;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
`ifdef MMS_STREAM_IDX_EN
    logic [3:0] out_idx;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mms_stream_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .select    (select),
        .len       (len),
        .busy      (busy),
        .len_err   (len_err),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef MMS_STREAM_IDX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic sel, input logic [3:0] n);
        start  = 1'b1;
        select = sel;
        len    = n;
        cycle();
        start  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({busy, len_err, in_ready, out_valid} !== 4'b0000) begin
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {busy, len_err, in_ready, out_valid});
            errors++;
        end
        vectors++;
        if (out_data !== 8'd0) begin
            $display("[TB] FAIL reset_data: got %0d expected 0", out_data);
            errors++;
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_max_frame();
        begin_frame(1'b0, 4'd4);
        vectors++;
        if ({busy, in_ready} !== 2'b11) begin
            $display("[TB] FAIL max_accum_entry: got %b expected 11", {busy, in_ready});
            errors++;
        end
        push(8'd3);
        push(8'd200);
        push(8'd17);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL max_early_valid: got %b expected 0", out_valid);
            errors++;
        end
        push(8'd200);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd200) begin
            $display("[TB] FAIL max_result: got valid=%b data=%0d expected valid=1 data=200", out_valid, out_data);
            errors++;
        end
`ifdef MMS_STREAM_IDX_EN
        vectors++;
        if (out_idx !== 4'd1) begin
            $display("[TB] FAIL max_idx: got %0d expected 1", out_idx);
            errors++;
        end
`endif
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        vectors++;
        if ({busy, out_valid} !== 2'b00) begin
            $display("[TB] FAIL max_release: got %b expected 00", {busy, out_valid});
            errors++;
        end
    endtask

    task automatic test_min_gaps();
        logic [7:0] vals [4];
        vals[0] = 8'd90; vals[1] = 8'd5; vals[2] = 8'd255; vals[3] = 8'd5;
        begin_frame(1'b1, 4'd4);
        for (int i = 0; i < 4; i++) begin
            push(vals[i]);
            if (i < 3) begin
                vectors++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    $display("[TB] FAIL min_gap_%0d: got ready=%b valid=%b expected ready=1 valid=0", i, in_ready, out_valid);
                    errors++;
                end
                cycle();
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd5) begin
            $display("[TB] FAIL min_result: got valid=%b data=%0d expected valid=1 data=5", out_valid, out_data);
            errors++;
        end
`ifdef MMS_STREAM_IDX_EN
        vectors++;
        if (out_idx !== 4'd1) begin
            $display("[TB] FAIL min_idx: got %0d expected 1", out_idx);
            errors++;
        end
`endif
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        begin_frame(1'b0, 4'd1);
        push(8'd0);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'd0) begin
                $display("[TB] FAIL hold_%0d: got valid=%b data=%0d expected valid=1 data=0", i, out_valid, out_data);
                errors++;
            end
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        vectors++;
        if ({busy, out_valid} !== 2'b00) begin
            $display("[TB] FAIL hold_release: got %b expected 00", {busy, out_valid});
            errors++;
        end
    endtask

    task automatic test_len_bounds();
        begin_frame(1'b0, 4'd0);
        vectors++;
        if (len_err !== 1'b1 || busy !== 1'b0) begin
            $display("[TB] FAIL len0_pulse: got err=%b busy=%b expected err=1 busy=0", len_err, busy);
            errors++;
        end
        cycle();
        vectors++;
        if (len_err !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL len0_clear: got err=%b busy=%b expected err=0 busy=0", len_err, busy);
            errors++;
        end
        begin_frame(1'b0, 4'd15);
        for (int v = 1; v <= 14; v++) begin
            push(8'(v));
        end
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            $display("[TB] FAIL len15_early: got valid=%b busy=%b expected valid=0 busy=1", out_valid, busy);
            errors++;
        end
        push(8'd15);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd15) begin
            $display("[TB] FAIL len15_result: got valid=%b data=%0d expected valid=1 data=15", out_valid, out_data);
            errors++;
        end
`ifdef MMS_STREAM_IDX_EN
        vectors++;
        if (out_idx !== 4'd14) begin
            $display("[TB] FAIL len15_idx: got %0d expected 14", out_idx);
            errors++;
        end
`endif
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        begin_frame(1'b0, 4'd4);
        push(8'd40);
        push(8'd50);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, len_err, in_ready, out_valid} !== 4'b0000 || out_data !== 8'd0) begin
            $display("[TB] FAIL abort_async: got ctrl=%b data=%0d expected ctrl=0000 data=0",
                     {busy, len_err, in_ready, out_valid}, out_data);
            errors++;
        end
        cycle();
        rst_n = 1'b1;
        cycle();
        begin_frame(1'b1, 4'd2);
        push(8'd7);
        push(8'd9);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd7) begin
            $display("[TB] FAIL abort_refr: got valid=%b data=%0d expected valid=1 data=7", out_valid, out_data);
            errors++;
        end
`ifdef MMS_STREAM_IDX_EN
        vectors++;
        if (out_idx !== 4'd0) begin
            $display("[TB] FAIL abort_idx: got %0d expected 0", out_idx);
            errors++;
        end
`endif
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        begin_frame(1'b0, 4'd1);
        push(8'd42);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd42) begin
            $display("[TB] FAIL b2b_result: got valid=%b data=%0d expected valid=1 data=42", out_valid, out_data);
            errors++;
        end
        start     = 1'b1;
        len       = 4'd3;
        out_ready = 1'b1;
        cycle();
        start     = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if ({busy, out_valid, in_ready} !== 3'b000) begin
            $display("[TB] FAIL b2b_idle: got %b expected 000", {busy, out_valid, in_ready});
            errors++;
        end
        cycle();
        vectors++;
        if (busy !== 1'b0) begin
            $display("[TB] FAIL b2b_no_queue: got busy=%b expected 0", busy);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_max_frame();
        test_min_gaps();
        test_backpressure();
        test_len_bounds();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mms_stream_ctrl.md
Name: mms_stream_ctrl

Overview:
- Sequencing controller for the max/min select datapath; reduces a frame of LEN unsigned numbers to a single max or min.
- Operands arrive on a valid/ready stream. One shared 2-operand compare/select stage is reused each cycle against an accumulator.
- The result is presented on a valid/ready output.
- Sits between a sample source and any consumer that needs a frame extreme value.

Parameters:
- DATA_W, 8, operand/result width, unsigned.
- CNT_W, 4, width of LEN and internal counters; max frame length 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  frame start request; sampled in IDLE only.
- select  input  1  0 = max, 1 = min; latched with start.
- len  input  CNT_W  frame length; latched with start.
- busy  output  1  high when state != IDLE.
- len_err  output  1  one-cycle pulse: start seen in IDLE with len==0.
- in_valid  input  1  operand valid.
- in_data  input  DATA_W  operand.
- in_ready  output  1  high only in ACCUM.
- out_valid  output  1  result valid, high only in DONE.
- out_data  output  DATA_W  reduced result.
- out_ready  input  1  consumer accepts result.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE; busy, len_err, in_ready, out_valid = 0; out_data, accumulator, counters, latched select = 0.
- IDLE:
  - start=1 and len!=0: latch select and len, clear count, go to ACCUM.
  - start=1 and len==0: pulse len_err for 1 cycle, stay IDLE.
- ACCUM:
  - in_ready=1. A transfer occurs when in_valid & in_ready.
  - First transfer loads the accumulator directly.
  - Each later transfer: accumulator <= select ? min(acc, in_data) : max(acc, in_data). Unsigned compare.
  - Ties keep the existing accumulator, so the earliest occurrence wins.
  - count increments per transfer. On the transfer where count reaches latched len, go to DONE.
  - in_valid=0 stalls with no state change.
- DONE:
  - out_valid=1 and out_data=accumulator, registered.
  - Result appears the cycle after the last operand transfer, i.e. latency 1 cycle from the last accept.
  - out_data holds stable while out_valid & !out_ready.
  - out_valid & out_ready: go to IDLE next cycle, out_valid drops.
- Simultaneous events:
  - start outside IDLE is ignored, with no queuing. This includes start in the same cycle as the DONE handshake.
  - Changes on select or len mid-frame have no effect.
- len = 2^CNT_W-1 is supported. The counter must not wrap before the comparison with len.
- rst_n asserted mid-frame aborts immediately to reset values. No partial result is emitted.
- out_data outside DONE is don't-care for checking, but has no X after reset.

Optional Feature:
- Macro: MMS_STREAM_IDX_EN.
- When defined:
  - Adds output out_idx, width CNT_W: the 0-based position within the frame of the element that produced out_data.
  - Ties report the earliest index.
  - Valid with out_valid and held with out_data; reset value 0.
- When undefined:
  - The port and its tracking register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then start, select=0, len=4; stream 8'd3, 8'd200, 8'd17, 8'd200 with in_valid continuous -> out_valid the cycle after the 4th accept, out_data=200. With MMS_STREAM_IDX_EN, out_idx=1.
- select=1, len=4; stream 8'd90, 8'd5, 8'd255, 8'd5 with in_valid gaps every other cycle -> out_data=5 (out_idx=1). in_ready stays high through the gaps; no extra transfers are counted.
- len=1, select=0, data 8'd0 -> DONE after one accept, out_data=0. Hold out_ready=0 for 5 cycles -> out_valid and out_data stable; out_ready=1 -> IDLE next cycle, busy=0.
- start with len=0 -> len_err high for exactly 1 cycle, busy stays 0. start with len=15 and 15 ascending values 1..15, select=0 -> out_data=15, no counter wrap.
- Mid-ACCUM after 2 of 4 operands, assert rst_n=0 asynchronously -> all outputs 0 immediately. After release, a new frame len=2 with values 7, 9, select=1 -> out_data=7.
- In DONE, pulse start together with out_ready=1 -> frame completes, start is ignored, block returns to IDLE with busy=0.
